// File: rtl/dmem_access_ctrl_if.sv
// Bundle of pipeline-request, cache and snoop signals seen by the data-memory access controller.
// The slave modport is the controller's view; master is the pipeline/cache side.
interface dmem_access_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req_ren;
   logic              req_wen;
   logic              req_atomic;
   logic              req_halt;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              pipe_advance;
   logic              dhit;
   logic [DATA_W-1:0] dmemload;
   logic              snoop_inv;
   logic [ADDR_W-1:0] snoop_addr;
   logic              dmemREN;
   logic              dmemWEN;
   logic              datomic;
   logic [ADDR_W-1:0] dmemaddr;
   logic [DATA_W-1:0] dmemstore;
   logic              pipe_enable;
   logic [DATA_W-1:0] rdata;
   logic              link_valid;
   logic [ADDR_W-1:0] link_addr;

   modport slave (
      input  req_ren, req_wen, req_atomic, req_halt, req_addr, req_wdata,
             pipe_advance, dhit, dmemload, snoop_inv, snoop_addr,
      output dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
             pipe_enable, rdata, link_valid, link_addr
   );

   modport master (
      output req_ren, req_wen, req_atomic, req_halt, req_addr, req_wdata,
             pipe_advance, dhit, dmemload, snoop_inv, snoop_addr,
      input  dmemREN, dmemWEN, datomic, dmemaddr, dmemstore,
             pipe_enable, rdata, link_valid, link_addr
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Memory-stage cache access controller: one transaction per instruction, stall until dhit,
// load-data hold while the EX/MEM latch is frozen, and the LL/SC link register.
module dmem_access_ctrl #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter int LINK_EN = 1
) (
   input logic               CLK,
   input logic               nRST,
   dmem_access_ctrl_if.slave bus
);

   localparam int   W    = $clog2(DATA_W / 8);
   localparam logic LINK = (LINK_EN != 0);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, next_state;
   logic              ren, wen, atom;
   logic              pipe_en;
   logic              complete;
   logic [DATA_W-1:0] cdata;
   logic [DATA_W-1:0] hold;
   logic              link_q;
   logic [ADDR_W-1:0] link_addr_q;

   logic req, is_ll, is_sc, is_st, sc_ok;

   // Word-granular compare: byte-offset bits are shifted out so they never matter.
   function automatic logic match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
      return ((a ^ b) >> W) == '0;
   endfunction

   assign req   = (bus.req_ren | bus.req_wen) & ~bus.req_halt;
   assign is_ll = LINK & bus.req_ren & bus.req_atomic;
   assign is_sc = LINK & bus.req_wen & bus.req_atomic;
   assign is_st = bus.req_wen & ~is_sc;
   assign sc_ok = link_q & match(bus.req_addr, link_addr_q)
                  & ~(bus.snoop_inv & match(bus.snoop_addr, link_addr_q));

   always_comb begin
      next_state = state;
      ren        = 1'b0;
      wen        = 1'b0;
      atom       = 1'b0;
      pipe_en    = 1'b1;
      complete   = 1'b0;
      cdata      = hold;
      case (state)
         IDLE: begin
            if (req) begin
               if (is_sc && !sc_ok) begin
                  complete = 1'b1;
                  cdata    = '0;
               end else begin
                  ren  = bus.req_ren;
                  wen  = bus.req_wen;
                  atom = bus.req_atomic & LINK;
                  if (bus.dhit) begin
                     complete = 1'b1;
                     cdata    = is_sc ? DATA_W'(1) : bus.dmemload;
                  end else begin
                     next_state = BUSY;
                     pipe_en    = 1'b0;
                  end
               end
            end
         end
         BUSY: begin
            // An SC reaching BUSY already passed its link check and is committed.
            if (bus.req_halt) begin
               next_state = IDLE;
            end else begin
               ren  = bus.req_ren;
               wen  = bus.req_wen;
               atom = bus.req_atomic & LINK;
               if (bus.dhit) begin
                  complete = 1'b1;
                  cdata    = is_sc ? DATA_W'(1) : bus.dmemload;
               end else begin
                  pipe_en = 1'b0;
               end
            end
         end
         DONE: begin
            if (bus.pipe_advance) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (complete) next_state = bus.pipe_advance ? IDLE : DONE;
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= IDLE;
         hold        <= '0;
         link_q      <= 1'b0;
         link_addr_q <= '0;
      end else begin
         state <= next_state;
         if (complete) hold <= cdata;
         // Link priority: LL set > SC success > matching plain store > matching snoop.
         if (complete && is_ll) begin
            link_q      <= 1'b1;
            link_addr_q <= bus.req_addr;
         end else if (complete && is_sc && wen) begin
            link_q <= 1'b0;
         end else if (complete && is_st && match(bus.req_addr, link_addr_q)) begin
            link_q <= 1'b0;
         end else if (bus.snoop_inv && match(bus.snoop_addr, link_addr_q)) begin
            link_q <= 1'b0;
         end
      end
   end

   assign bus.dmemREN     = ren;
   assign bus.dmemWEN     = wen;
   assign bus.datomic     = atom;
   assign bus.dmemaddr    = bus.req_addr;
   assign bus.dmemstore   = bus.req_wdata;
   assign bus.pipe_enable = pipe_en;
   assign bus.rdata       = complete ? cdata : hold;
   assign bus.link_valid  = link_q & LINK;
   assign bus.link_addr   = link_addr_q;

endmodule
